uart_rx_cfg: RTL

//  Parametrised UART receiver, successor to the fixed 8N1 receiver: configurable

---
 rtl/uart_rx_cfg.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
// Parametrised UART receiver. Configurable data width (LSB first), parity and
// stop-bit count. Each bit is decided by a 3-sample majority vote around the
// bit centre. Parity, framing and break errors are reported with each character.
//
// Ports
//   i_Clock       system clock
//   i_Rst_L       asynchronous active-low reset
//   i_Rx_Serial   asynchronous serial line, idle high
//   o_Rx_DV       one-cycle pulse: character and flags valid
//   o_Rx_Data     received character, held until next DV
//   o_Parity_Err  parity mismatch (qualified by o_Rx_DV)
//   o_Frame_Err   a stop bit was sampled 0 (qualified by o_Rx_DV)
//   o_Break       data, parity and stop all sampled 0 (qualified by o_Rx_DV)
//   o_Busy        high whenever the receiver is not in IDLE
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [1:0]           fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 fe_q, fe_d;
  logic                 zero_q, zero_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pe_out_q, pe_out_d;
  logic                 fe_out_q, fe_out_d;
  logic                 brk_q, brk_d;

  logic rx_s;
  logic vote;
  logic in_frame;

  assign rx_s     = sync2_q;
  assign vote     = maj3(s0_q, s1_q, rx_s);
  assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_WAIT_HIGH;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      fill_q   <= 2'b00;
      cnt_q    <= '0;
      idx_q    <= '0;
      s0_q     <= 1'b1;
      s1_q     <= 1'b1;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      fe_q     <= 1'b0;
      zero_q   <= 1'b0;
      dv_q     <= 1'b0;
      data_q   <= '0;
      pe_out_q <= 1'b0;
      fe_out_q <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      fe_q     <= fe_d;
      zero_q   <= zero_d;
      dv_q     <= dv_d;
      data_q   <= data_d;
      pe_out_q <= pe_out_d;
      fe_out_q <= fe_out_d;
      brk_q    <= brk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync1_d  = i_Rx_Serial;
    sync2_d  = sync1_q;
    // fill_q marks when the synchroniser holds real pin samples rather than
    // its reset value, so WAIT_HIGH cannot be fooled right after reset.
    fill_d   = {fill_q[0], 1'b1};
    cnt_d    = '0;
    idx_d    = idx_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    fe_d     = fe_q;
    zero_d   = zero_q;
    dv_d     = 1'b0;
    data_d   = data_q;
    pe_out_d = pe_out_q;
    fe_out_d = fe_out_q;
    brk_d    = brk_q;

    if (in_frame) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      if (cnt_q == CNT_S0) s0_d = rx_s;
      if (cnt_q == CNT_S1) s1_d = rx_s;
    end

    case (state_q)
      ST_WAIT_HIGH: begin
        if (fill_q[1] && rx_s) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        // The cycle the low level is seen is count 0 of the start bit.
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_ONE;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_VOTE && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
          idx_d   = '0;
          perr_d  = 1'b0;
          fe_d    = 1'b0;
          zero_d  = 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_VOTE) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~vote;
        end
        if (cnt_q == CNT_LAST) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_VOTE) begin
          zero_d = zero_q & ~vote;
          perr_d = (vote != ((^shift_q) ^ PAR_ODD));
        end
        if (cnt_q == CNT_LAST) state_d = ST_STOP;
      end

      ST_STOP: begin
        if (cnt_q == CNT_VOTE) begin
          if (idx_q == STOP_LAST) begin
            // Character is reported at the last stop vote, not at end of bit,
            // so a start edge right after the stop bit is never missed.
            dv_d     = 1'b1;
            data_d   = shift_q;
            pe_out_d = perr_q;
            fe_out_d = fe_q | ~vote;
            brk_d    = zero_q & ~vote;
            cnt_d    = '0;
            state_d  = vote ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            fe_d   = fe_q | ~vote;
            zero_d = zero_q & ~vote;
          end
        end
        if (cnt_q == CNT_LAST) idx_d = idx_q + 4'd1;
      end

      default: state_d = ST_WAIT_HIGH;
    endcase
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Data    = data_q;
  assign o_Parity_Err = pe_out_q;
  assign o_Frame_Err  = fe_out_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule
